// File: rtl/regfile_sequencer.sv
// Multi-cycle control unit for the 4x8-bit register file: fetches 8-bit
// instructions, runs a FETCH/DECODE/EXEC/WB sequence and drives the write port.
module regfile_sequencer #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [7:0]        instr_data,
  output logic [1:0]        read_register1,
  output logic [1:0]        read_register2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic [1:0]        write_register,
  output logic              reg_write,
  output logic [DATA_W-1:0] write_data,
  output logic              halted,
  output logic              zero_flag,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MOVI = 2'b10,
    OP_JMP  = 2'b11
  } opcode_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [7:0]        ir_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] alu_result;
  logic [PC_W-1:0]   jmp_target;
  logic              self_jump;
  opcode_t           op;
  logic              reg_write_d;
  logic              halted_d;

  assign op         = opcode_t'(ir_q[7:6]);
  assign jmp_target = PC_W'(ir_q[5:0]);
  assign self_jump  = (jmp_target == pc_q);

  assign instr_addr = pc_q;
  assign write_data = result_q;
  assign state      = state_q;

  always_comb begin
    alu_result = '0;
    unique case (op)
      OP_ADD:  alu_result = read_data1 + read_data2;
      OP_SUB:  alu_result = read_data1 - read_data2;
      OP_MOVI: alu_result = DATA_W'(ir_q[3:0]);
      OP_JMP:  alu_result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op == OP_JMP) state_d = self_jump ? S_HALT : S_FETCH;
        else              state_d = S_WB;
      end
      S_WB:     state_d = run ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: strobes are decoded from the next state and then registered
  always_comb begin
    reg_write_d = (state_d == S_WB);
    halted_d    = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write <= 1'b0;
      halted    <= 1'b0;
    end else begin
      reg_write <= reg_write_d;
      halted    <= halted_d;
    end
  end

  // Datapath; the write address and result only move in EXEC, so they are
  // stable across the whole WB strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q           <= '0;
      ir_q           <= '0;
      result_q       <= '0;
      read_register1 <= '0;
      read_register2 <= '0;
      write_register <= '0;
      zero_flag      <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: ir_q <= instr_data;
        S_DECODE: begin
          read_register1 <= ir_q[5:4];
          read_register2 <= ir_q[3:2];
        end
        S_EXEC: begin
          if (op == OP_JMP) begin
            if (!self_jump) pc_q <= jmp_target;
          end else begin
            result_q       <= alu_result;
            write_register <= (op == OP_MOVI) ? ir_q[5:4] : ir_q[1:0];
          end
        end
        S_WB: begin
          zero_flag <= (result_q == '0);
          pc_q      <= pc_q + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: behavioural ROM and register file,
// with a write scoreboard checked on every reg_write pulse.
module tb_regfile_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic [7:0] instr_addr;
  logic [7:0] instr_data;
  logic [1:0] read_register1, read_register2;
  logic [7:0] read_data1, read_data2;
  logic [1:0] write_register;
  logic       reg_write;
  logic [7:0] write_data;
  logic       halted;
  logic       zero_flag;
  logic [2:0] state;

  regfile_sequencer #(.PC_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .run(run),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .read_register1(read_register1), .read_register2(read_register2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_register(write_register), .reg_write(reg_write),
    .write_data(write_data), .halted(halted), .zero_flag(zero_flag),
    .state(state)
  );

  typedef struct { logic [1:0] r; logic [7:0] d; } wr_t;

  logic [7:0] rom  [256];
  logic [7:0] regs [4];
  wr_t        exp_q [$];
  int         wt    [$];
  int         errors = 0;
  int         checks = 0;
  int         wcount = 0;
  int         cyc    = 0;
  logic       prev_rw = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr_data = rom[instr_addr];
  assign read_data1 = regs[read_register1];
  assign read_data2 = regs[read_register2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (reg_write) begin
      regs[write_register] <= write_data;
    end
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected write and be one cycle wide
  always @(negedge clk) begin
    if (!reset) begin
      prev_rw = 1'b0;
    end else begin
      if (reg_write) begin
        chk("single_cycle_pulse", prev_rw, 1'b0);
        chk("write_expected", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_register", write_register, e.r);
          chk("write_data", write_data, e.d);
        end
        wcount++;
        wt.push_back(cyc);
      end
      prev_rw = reg_write;
    end
  end

  task automatic push(input logic [1:0] r, input logic [7:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic load_main;
    fill_rom(8'h00);
    rom[0] = 8'h95; rom[1] = 8'hA3; rom[2] = 8'h1B; rom[3] = 8'h64; rom[4] = 8'hC4;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    run   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    wt.delete();
    wcount = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (state == s) break;
    end
    chk(tag, state, s);
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b0;
    load_main();

    // 1. reset mid-WB of the ADD, then idle with run low
    do_reset();
    push(2'd1, 8'h05); push(2'd2, 8'h03); push(2'd3, 8'h08);
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (reg_write && write_register == 2'd3) break;
    end
    chk("t1_reached_add_wb", reg_write && write_register == 2'd3, 1'b1);
    reset = 1'b0;
    #1;
    chk("t1_rst_reg_write", reg_write, 1'b0);
    chk("t1_rst_state", state, 3'd0);
    chk("t1_rst_pc", instr_addr, 8'h00);
    chk("t1_rst_halted", halted, 1'b0);
    chk("t1_rst_write_data", write_data, 8'h00);
    chk("t1_rst_write_register", write_register, 2'd0);
    chk("t1_rst_rr1", read_register1, 2'd0);
    chk("t1_rst_rr2", read_register2, 2'd0);
    chk("t1_rst_zero_flag", zero_flag, 1'b0);
    exp_q.delete();
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t1_idle_state", state, 3'd0);
      chk("t1_idle_no_write", reg_write, 1'b0);
    end

    // 2. main program
    do_reset();
    push(2'd1, 8'h05); push(2'd2, 8'h03); push(2'd3, 8'h08); push(2'd0, 8'hFE);
    run = 1'b1;
    wait_state(3'd5, 100, "t2_halt_state");
    chk("t2_all_writes_seen", exp_q.size(), 0);
    chk("t2_nwrites", wt.size(), 4);
    if (wt.size() == 4)
      for (int i = 1; i < 4; i++) chk("t2_write_spacing", wt[i] - wt[i-1], 4);
    #4;
    chk("t2_halted", halted, 1'b1);
    chk("t2_halt_pc", instr_addr, 8'h04);
    chk("t2_zero_flag", zero_flag, 1'b0);
    chk("t2_r0", regs[0], 8'hFE);
    chk("t2_r3", regs[3], 8'h08);
    run = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t2_halt_sticky", state, 3'd5);
    end

    // 3a. SUB r1 = r1 - r1
    fill_rom(8'h00);
    rom[0] = 8'h95; rom[1] = 8'h55; rom[2] = 8'hC2;
    do_reset();
    push(2'd1, 8'h05); push(2'd1, 8'h00);
    run = 1'b1;
    wait_state(3'd5, 60, "t3a_halt");
    chk("t3a_writes_seen", exp_q.size(), 0);
    chk("t3a_zero_flag", zero_flag, 1'b1);
    chk("t3a_r1", regs[1], 8'h00);

    // 3b. ADD r1 = r1 + r1 uses the old value
    rom[1] = 8'h15;
    do_reset();
    push(2'd1, 8'h05); push(2'd1, 8'h0A);
    run = 1'b1;
    wait_state(3'd5, 60, "t3b_halt");
    chk("t3b_writes_seen", exp_q.size(), 0);
    chk("t3b_zero_flag", zero_flag, 1'b0);
    chk("t3b_r1", regs[1], 8'h0A);

    // 4. run dropped during DECODE of instruction 2
    load_main();
    do_reset();
    push(2'd1, 8'h05); push(2'd2, 8'h03); push(2'd3, 8'h08);
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (state == 3'd2 && instr_addr == 8'h02) break;
    end
    chk("t4_in_decode2", state, 3'd2);
    run = 1'b0;
    wait_state(3'd0, 20, "t4_idle");
    chk("t4_idle_pc", instr_addr, 8'h03);
    chk("t4_wb_completed", exp_q.size(), 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("t4_stays_idle", state, 3'd0);
    end
    push(2'd0, 8'hFE);
    run = 1'b1;
    wait_state(3'd1, 5, "t4_resume_fetch");
    chk("t4_resume_addr", instr_addr, 8'h03);
    wait_state(3'd5, 40, "t4_halt");
    chk("t4_r0", regs[0], 8'hFE);

    // 5a. PC wrap with MOVI r0,1 everywhere
    fill_rom(8'h81);
    do_reset();
    for (int i = 0; i < 258; i++) push(2'd0, 8'h01);
    run = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk); #1;
      if (wcount == 256) break;
    end
    chk("t5a_count_256", wcount, 256);
    chk("t5a_pc_before_wrap", instr_addr, 8'hFF);
    @(posedge clk); #1;
    chk("t5a_pc_wrapped", instr_addr, 8'h00);
    chk("t5a_fetch_after_wrap", state, 3'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (wcount == 258) break;
    end
    run = 1'b0;
    chk("t5a_continues", wcount, 258);
    wait_state(3'd0, 10, "t5a_idle");
    chk("t5a_writes_seen", exp_q.size(), 0);
    chk("t5a_idle_pc", instr_addr, 8'h02);

    // 5b. JMP 0x3F from 0x10, no writes
    rom[0] = 8'hD0; rom[8'h10] = 8'hFF; rom[8'h3F] = 8'hFF;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (state == 3'd3 && instr_addr == 8'h10) break;
    end
    chk("t5b_exec_at_10", instr_addr, 8'h10);
    @(posedge clk); #1;
    chk("t5b_fetch_state", state, 3'd1);
    chk("t5b_fetch_addr", instr_addr, 8'h3F);
    wait_state(3'd5, 10, "t5b_halt");
    chk("t5b_halt_pc", instr_addr, 8'h3F);
    chk("t5b_no_writes", wcount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle control unit that sequences the 4×8-bit register file of the 8-bit microprocessor.
- Fetches 8-bit instructions from an external instruction ROM and decodes them.
- Drives the register file's read addresses, write address, write strobe and write data through a FETCH/DECODE/EXEC/WB state machine with a small internal ALU.
- Provides run/idle control, halt detection and a zero flag for the top level and the debug display.

Parameters:
- PC_W, 8, program counter / instruction address width; PC wraps modulo 2^PC_W.
- DATA_W, 8, datapath width; ALU, write_data and read_data widths.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- run  input  1  1 = execute instructions; 0 = stop at the next instruction boundary.
- instr_addr  output  PC_W  current PC, presented to the instruction ROM.
- instr_data  input  8  instruction word; combinational ROM output for instr_addr.
- read_register1  output  2  register file read port 1 address.
- read_register2  output  2  register file read port 2 address.
- read_data1  input  DATA_W  register file read port 1 data; combinational.
- read_data2  input  DATA_W  register file read port 2 data; combinational.
- write_register  output  2  register file write address.
- reg_write  output  1  active-high write strobe, exactly one clk cycle wide.
- write_data  output  DATA_W  register file write data.
- halted  output  1  1 while in the HALT state.
- zero_flag  output  1  1 if the last written ALU result was 0.
- state  output  3  current FSM state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.

Behaviour:

Instruction format (IR = registered instruction):
- IR[7:6] is the opcode.
- 00 ADD: rd = rs + rt.
- 01 SUB: rd = rs − rt.
- 10 MOVI: IR[5:4] = {4'b0, IR[3:0]}.
- 11 JMP: PC = {zeros, IR[5:0]}.
- Field positions: rs = IR[5:4], rt = IR[3:2], rd = IR[1:0].

Reset (asynchronous, reset = 0), all immediate:
- state = IDLE; PC = 0; IR = 0; result register = 0.
- reg_write = 0, write_data = 0, write_register = 0.
- read_register1 = read_register2 = 0.
- halted = 0, zero_flag = 0.
- Reset asserted mid-instruction abandons the instruction. reg_write must drop in the same instant, with no partial write issued afterwards.

FSM, one transition per clk edge:
- IDLE: if run = 1 → FETCH, else stay.
- FETCH: instr_addr = PC; IR <= instr_data → DECODE.
- DECODE:
  - read_register1 <= IR[5:4], read_register2 <= IR[3:2].
  - These stay held through EXEC and WB.
  - → EXEC.
- EXEC, by opcode:
  - ADD/SUB: result <= (read_data1 ± read_data2) mod 2^DATA_W; carry/borrow discarded → WB.
  - MOVI: result <= zero-extended IR[3:0] → WB.
  - JMP, target ≠ PC: PC <= target → FETCH (ignores run).
  - JMP, target = PC: → HALT (self-jump = halt).
- WB:
  - reg_write = 1 for this cycle only.
  - write_register = IR[1:0] for ADD/SUB, IR[5:4] for MOVI.
  - write_data = result, stable for the whole cycle.
  - zero_flag <= (result == 0).
  - PC <= PC + 1, wrapping 2^PC_W − 1 → 0.
  - → FETCH if run = 1, else IDLE.
- HALT: halted = 1, reg_write = 0; stays until reset, and run is ignored.

Timing and control rules:
- Latency: ALU and MOVI instructions take 4 cycles (FETCH→WB); JMP takes 3 cycles (FETCH→EXEC).
- run is sampled only in IDLE and WB. Deasserting it mid-instruction still completes that instruction's WB.
- reg_write is 0 in every state except WB, and write_data / write_register are never changed while reg_write = 1.
- All outputs are registered, except instr_addr, which is the PC register itself.
- Reading and writing the same register in one instruction (e.g. ADD r1 = r1 + r1) uses the old value, because operands are consumed in EXEC before WB.
- A JMP target above 63 is not encodable; the upper PC bits are always cleared by JMP.

Test Plan:
1. Reset/idle:
   - Drive reset = 0 mid-WB of an ADD → reg_write = 0 immediately, state = 0, PC = 0, halted = 0.
   - Release reset with run = 0 for 10 cycles → state stays 0 and reg_write never pulses.
2. Program execution (ROM 0:0x95, 1:0xA3, 2:0x1B, 3:0x64, 4:0xC4; behavioural 4×8 register file attached; run = 1):
   - Writes occur in order: r1 = 0x05, r2 = 0x03, r3 = 0x08, r0 = 0xFE (3 − 5 wraps).
   - Each write is a single-cycle reg_write pulse, 4 cycles apart.
   - After the writes: halted = 1 at PC = 4, zero_flag = 0.
3. Zero flag and self-operand:
   - Program 0x95 (MOVI r1,5), then 0x55 (SUB r1 = r1 − r1) → r1 = 0x00, zero_flag = 1.
   - Program MOVI r1,5, then ADD r1 = r1 + r1 → r1 = 0x0A.
4. Run stop:
   - Deassert run during DECODE of instruction 2 → instruction completes its WB, then state = IDLE with PC = 3.
   - Reassert run → execution resumes at address 3.
5. PC wrap:
   - Fill ROM with MOVI only (0x81), run 256 instructions → PC returns to 0 and execution continues.
   - JMP 0x3F (0xFF) from PC 0x10 → next fetch at 0x3F, no reg_write pulse.
